mul_sched: RTL and testbench

Round-robin scheduler that shares one 4-bit sequential shift-add multiplier among N_REQ requesters. It arbitrates requests, launches the shared multiplier core with the winner's operands, and returns the 8-bit product tagged with the winner's ID through a valid/ready result port. It sits between the requester-side control logic and the multiplier datapath; only one multiplication is in flight at any time.

---
 rtl/mul_sched_pkg.sv | 15 +
 rtl/seq_mul_core.sv | 50 +++++
 rtl/mul_sched.sv | 130 +++++++++++++
 tb/tb_mul_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the mul_sched scheduler and its multiplier core.
package mul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int OP_W  = 4;
  localparam int RES_W = 8;
  localparam int ITER  = 4;
  localparam int CNT_W = $clog2(ITER + 1);

endpackage

// File: rtl/seq_mul_core.sv
// 4-bit sequential shift-add multiplier: one iteration per cycle after start.
// done is high in the cycle of the last iteration, with p showing that iteration's result.
module seq_mul_core
  import mul_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             done,
  output logic [RES_W-1:0] p
);

  logic [OP_W-1:0]    a_reg;
  logic [2*OP_W:0]    acc;
  logic [CNT_W-1:0]   cnt;
  logic               run;
  logic [OP_W:0]      upper;
  logic [2*OP_W:0]    acc_step;

  always_comb begin
    upper    = acc[2*OP_W:OP_W] + (acc[0] ? {1'b0, a_reg} : '0);
    acc_step = {1'b0, upper, acc[OP_W-1:1]};
  end

  // p is taken from the combinational next value so the scheduler can latch it
  // on the same edge that retires the last iteration.
  assign done = run && (cnt == CNT_W'(1));
  assign p    = acc_step[RES_W-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
    end else if (start) begin
      a_reg <= a;
      acc   <= {{(OP_W+1){1'b0}}, b};
      cnt   <= CNT_W'(ITER);
      run   <= 1'b1;
    end else if (run) begin
      acc <= acc_step;
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) run <= 1'b0;
    end
  end

endmodule

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one sequential multiplier among N_REQ requesters.
// Optional build macro MUL_SCHED_BYPASS_EN: zero operands skip the core and finish in one cycle.
//
// state | meaning
// IDLE  | arbitrating; winner granted and launched at the edge
// BUSY  | core iterating; result latched on core done
// DONE  | result held on res_* until res_valid && res_ready
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_REQ-1:0]      req,
  input  logic [OP_W*N_REQ-1:0] a_in,
  input  logic [OP_W*N_REQ-1:0] b_in,
  output logic [N_REQ-1:0]      gnt,
  output logic                  res_valid,
  output logic [RES_W-1:0]      res_data,
  output logic [IDW-1:0]        res_id,
  input  logic                  res_ready
);

  state_t             state, state_nxt;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     cand;
  logic [IDW-1:0]     win;
  logic [IDW-1:0]     nxt_ptr;
  logic               found;
  logic [OP_W-1:0]    a_win;
  logic [OP_W-1:0]    b_win;
  logic               take;
  logic               start;
  logic               core_done;
  logic [RES_W-1:0]   core_p;
`ifdef MUL_SCHED_BYPASS_EN
  logic               bypass_hit;
`endif

  // Search starts at rr_ptr and wraps modulo N_REQ; first requesting index wins.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    cand    = '0;
    a_win   = '0;
    b_win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDW'((32'(rr_ptr) + 32'(k)) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == win) begin
        a_win = a_in[i*OP_W +: OP_W];
        b_win = b_in[i*OP_W +: OP_W];
      end
    end
    nxt_ptr = IDW'((32'(win) + 32'd1) % N_REQ);
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    start     = 1'b0;
    gnt       = '0;
`ifdef MUL_SCHED_BYPASS_EN
    bypass_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found && rstn) begin
          take = 1'b1;
          gnt  = N_REQ'(1) << win;
`ifdef MUL_SCHED_BYPASS_EN
          if (a_win == '0 || b_win == '0) begin
            bypass_hit = 1'b1;
            state_nxt  = DONE;
          end else begin
            start     = 1'b1;
            state_nxt = BUSY;
          end
`else
          start     = 1'b1;
          state_nxt = BUSY;
`endif
        end
      end
      BUSY: if (core_done) state_nxt = DONE;
      DONE: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      res_data <= '0;
      res_id   <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        res_id <= win;
        rr_ptr <= nxt_ptr;
`ifdef MUL_SCHED_BYPASS_EN
        if (bypass_hit) res_data <= '0;
`endif
      end else if (state == BUSY && core_done) begin
        res_data <= core_p;
      end
    end
  end

  assign res_valid = (state == DONE);

  seq_mul_core u_core (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .a     (a_win),
    .b     (b_win),
    .done  (core_done),
    .p     (core_p)
  );

endmodule

// File: tb/tb_mul_sched.sv
// Self-checking bench for mul_sched: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_mul_sched;

  localparam int N  = 4;
  localparam int IW = 2;
`ifdef MUL_SCHED_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   req;
  logic [4*N-1:0] a_in;
  logic [4*N-1:0] b_in;
  logic [N-1:0]   gnt;
  logic           res_valid;
  logic [7:0]     res_data;
  logic [IW-1:0]  res_id;
  logic           res_ready;

  mul_sched #(.N_REQ(N)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: pointer, one outstanding transaction and its due cycle
  int m_ptr  = 0;
  bit m_pend = 1'b0;
  int m_rdy  = 0;
  int m_data = 0;
  int m_id   = 0;
  int g_w    = -1;

  // observations from the last step
  int s_g     = -1;
  int s_valid = 0;
  int s_cyc   = 0;
  int s_data  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++)
      if (v[i]) r = (r == -1) ? i : -2;
    return r;
  endfunction

  function automatic int op_a(input int i);
    logic [4*N-1:0] t;
    t = a_in;
    return int'(t[i*4 +: 4]);
  endfunction

  function automatic int op_b(input int i);
    logic [4*N-1:0] t;
    t = b_in;
    return int'(t[i*4 +: 4]);
  endfunction

  task automatic step();
    logic [N-1:0] eg;
    bit ev;
    int w, lat, ga, gb;
    @(negedge clk);
    eg = '0;
    ev = 1'b0;
    w  = -1;
    s_g     = onehot_idx(gnt);
    s_valid = int'(res_valid);
    s_data  = int'(res_data);
    s_cyc   = cyc;
    if (!rstn) begin
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_valid", 32'(res_valid), 0);
      chk("rst_data", 32'(res_data), 0);
      chk("rst_id", 32'(res_id), 0);
    end else begin
      if (!m_pend) begin
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
      end
      if (w >= 0) eg[w] = 1'b1;
      ev = m_pend && (cyc >= m_rdy);
      chk("gnt", 32'(gnt), 32'(eg));
      chk("valid", 32'(res_valid), 32'(ev));
      if (ev) begin
        chk("data", 32'(res_data), 32'(m_data));
        chk("id", 32'(res_id), 32'(m_id));
      end
    end
    g_w = w;
    @(posedge clk);
    if (!rstn) begin
      m_ptr  = 0;
      m_pend = 1'b0;
      g_w    = -1;
    end else if (ev && res_ready) begin
      m_pend = 1'b0;
    end else if (w >= 0) begin
      ga     = op_a(w);
      gb     = op_b(w);
      lat    = (BYP && (ga == 0 || gb == 0)) ? 1 : 5;
      m_pend = 1'b1;
      m_rdy  = cyc + lat;
      m_data = ga * gb;
      m_id   = w;
      m_ptr  = (w + 1) % N;
    end
    cyc++;
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    a_in[i*4 +: 4] = 4'(a);
    b_in[i*4 +: 4] = 4'(b);
  endtask

  task automatic drain();
    req = '0;
    res_ready = 1'b1;
    for (int i = 0; i < 20 && m_pend; i++) step();
    step();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  function automatic int rand_op();
    return ($urandom_range(0, 99) < 20) ? 0 : int'($urandom_range(0, 15));
  endfunction

  task automatic rnd_update();
    for (int i = 0; i < N; i++) begin
      if (i == g_w) begin
        if ($urandom_range(0, 1) == 1) set_ops(i, rand_op(), rand_op());
        else req[i] = 1'b0;
      end else if (!req[i]) begin
        if ($urandom_range(0, 99) < 30) begin
          req[i] = 1'b1;
          set_ops(i, rand_op(), rand_op());
        end
      end else if ($urandom_range(0, 99) < 5) begin
        req[i] = 1'b0;
      end
    end
    res_ready = ($urandom_range(0, 99) < 60);
  endtask

  int t_g, t_v, v_data, d0, id0, other;
  int gq[$];
  int gc[$];

  initial begin
    rstn = 1'b0;
    req = '0;
    a_in = '0;
    b_in = '0;
    res_ready = 1'b0;
    step();
    step();
    rstn = 1'b1;

    // single requester, 7*7
    req = 4'b0001;
    set_ops(0, 7, 7);
    res_ready = 1'b1;
    t_g = -100; t_v = -1; v_data = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (t_g < 0 && s_g == 0) t_g = s_cyc;
      if (t_v < 0 && s_valid == 1) begin t_v = s_cyc; v_data = s_data; end
    end
    chk("t1_lat", 32'(t_v - t_g), 5);
    chk("t1_data", 32'(v_data), 49);
    drain();

    // contention, order 0,1,2,3,0 from a fresh pointer
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_ops(i, 15, 15);
    res_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (s_g >= 0) begin gq.push_back(s_g); gc.push_back(s_cyc); end
    end
    chk("t2_count", 32'(gq.size()), 5);
    if (gq.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("t2_order", 32'(gq[k]), 32'(k % 4));
        if (k > 0) chk("t2_gap", 32'(gc[k] - gc[k-1]), 6);
      end
    end
    drain();

    // back-pressure with req=0110
    req = 4'b0110;
    set_ops(1, 3, 5);
    set_ops(2, 2, 6);
    res_ready = 1'b0;
    for (int i = 0; i < 10 && s_valid == 0; i++) step();
    chk("t3_valid_seen", 32'(s_valid), 1);
    d0 = int'(res_data);
    id0 = int'(res_id);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_stable_data", 32'(res_data), 32'(d0));
      chk("t3_stable_id", 32'(res_id), 32'(id0));
      chk("t3_no_gnt", 32'(gnt), 0);
    end
    res_ready = 1'b1;
    step();
    step();
    other = (id0 == 1) ? 2 : 1;
    chk("t3_next_gnt", 32'(s_g), 32'(other));
    drain();

    // reset in cycle 2 of a BUSY operation
    req = 4'b0001;
    set_ops(0, 5, 3);
    step();
    chk("t4_gnt0", 32'(s_g), 0);
    req = '0;
    step();
    rstn = 1'b0;
    #1;
    chk("t4_rst_gnt", 32'(gnt), 0);
    chk("t4_rst_valid", 32'(res_valid), 0);
    chk("t4_rst_data", 32'(res_data), 0);
    chk("t4_rst_id", 32'(res_id), 0);
    step();
    step();
    req = 4'b0011;
    set_ops(1, 4, 4);
    rstn = 1'b1;
    step();
    chk("t4_first", 32'(s_g), 0);
    drain();

    // zero operand
    req = 4'b0010;
    set_ops(1, 0, 9);
    res_ready = 1'b1;
    t_g = -100; t_v = -1; v_data = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) req = '0;
      if (t_g < 0 && s_g == 1) t_g = s_cyc;
      if (t_v < 0 && s_valid == 1) begin t_v = s_cyc; v_data = s_data; end
    end
    chk("t5_lat", 32'(t_v - t_g), BYP ? 32'd1 : 32'd5);
    chk("t5_data", 32'(v_data), 0);
    drain();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rnd_update();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
